uart_line_arbiter: RTL and testbench
====================================

# uart_line_arbiter

Shares one APB mock UART between `NumReq` independent APB requesters (one per core bridge) in the cluster testbench. It arbitrates round-robin at APB-transfer granularity and holds a line lock. After a requester writes a non-newline character to the TX register, only that requester is served until it writes LF (0x0A) or stays idle for `TimeoutCycles`, so per-core printf output never interleaves mid-line.

## Interface
Parameters:
- `NumReq`, 8, number of APB requester ports (≥2)
- `AddrWidth`, 32, APB address width
- `TimeoutCycles`, 1024, idle cycles after which a held line lock is dropped (≥2)
- `TxAddrOffset`, 0, address of the UART TX data register (compared on full `AddrWidth`)

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, asynchronous, active-high
- `slv_psel_i`  in  NumReq  per-requester select
- `slv_penable_i`  in  NumReq  per-requester enable
- `slv_pwrite_i`  in  NumReq  per-requester write
- `slv_paddr_i`  in  NumReq×AddrWidth  per-requester address
- `slv_pwdata_i`  in  NumReq×32  per-requester write data
- `slv_pready_o`  out  NumReq  per-requester ready
- `slv_prdata_o`  out  NumReq×32  read data, valid only with own pready
- `slv_pslverr_o`  out  NumReq  error, valid only with own pready
- `mst_psel_o`  out  1  UART select
- `mst_penable_o`  out  1  UART enable
- `mst_pwrite_o`  out  1  UART write
- `mst_paddr_o`  out  AddrWidth  UART address
- `mst_pwdata_o`  out  32  UART write data
- `mst_pready_i`  in  1  UART ready
- `mst_prdata_i`  in  32  UART read data
- `mst_pslverr_i`  in  1  UART error
- `lock_valid_o`  out  1  line lock held
- `lock_owner_o`  out  $clog2(NumReq)  lock holder index

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: eligible set = `slv_psel_i`, masked to the owner bit when `lock_valid`. Pick the first eligible index at or after `rr_ptr` (wrapping). On a pick, latch grant index, pwrite, paddr and pwdata, then go to SETUP. With no eligible request, stay in IDLE.
- SETUP: `mst_psel_o`=1, `mst_penable_o`=0, latched fields driven. Always advance to ACCESS after one cycle.
- ACCESS: `mst_psel_o`=1, `mst_penable_o`=1. Remain until `mst_pready_i`. In the completing cycle:
  - `slv_pready_o[grant]` = `mst_pready_i & slv_penable_i[grant]` (combinational), with prdata and pslverr forwarded combinationally.
  - Return to IDLE and set `rr_ptr` = (grant+1) mod NumReq.
- Non-granted `slv_pready_o` bits are always 0. Non-granted `slv_prdata_o` lanes are 0.
- Lock update on a completing write with `pslverr`=0 and `paddr`==`TxAddrOffset`:
  - `pwdata[7:0]`≠0x0A: lock_valid=1, owner=grant, timeout counter cleared.
  - `pwdata[7:0]`==0x0A: lock_valid=0.
- Reads, other addresses and errored writes leave the lock unchanged.
- Timeout counter: increments each cycle the lock is held and the FSM is in IDLE with `slv_psel_i[owner]`=0. It is cleared whenever the owner is granted. When it reaches `TimeoutCycles`-1 the lock clears on the next edge. The counter saturates and never wraps.
- Simultaneous events: a lock release (LF or timeout) in a cycle makes every requester eligible from the following IDLE cycle.

## Timing
- Reset values: all `mst_*` outputs 0, all `slv_pready_o` 0, all `slv_prdata_o` 0, all `slv_pslverr_o` 0, `lock_valid_o` 0, `lock_owner_o` 0. Internally: FSM in IDLE, `rr_ptr` 0, counter 0.
- Reset asserted mid-transfer aborts the transfer immediately. No pready is issued for the aborted transfer.
- Latency: request visible in IDLE at cycle t gives SETUP at t+1 and ACCESS at t+2. With a zero-wait slave it completes at t+2, so back-to-back transfers take 3 cycles each.
- Requesters hold psel, addr, data and write stable until their own pready.
- Master-side signals are registered. Only slave-side pready, prdata and pslverr are combinational from `mst_*_i`.

## Structure
- Package `uart_arb_pkg`: state enum `arb_state_e` {IDLE, SETUP, ACCESS} and constant `AsciiLf` = 8'h0A.
- Sub-module `uart_rr_pick`: combinational round-robin picker. Inputs are the request vector and the start pointer; outputs are valid and index.

## Test plan
- Single requester 3 writes "A","B",LF to TxAddrOffset, zero-wait UART: each completes 3 cycles after psel. lock_valid rises after "A" and falls after LF.
- Req 0 and req 5 request simultaneously from reset with no lock, using reads: grant order 0, 5, 0, 5 while both keep requesting.
- Req 2 writes "x" and holds the lock while req 3 requests: req 3 gets no pready until req 2 writes LF, then is served in the next IDLE.
- Req 2 takes the lock then goes silent with TimeoutCycles=16: the lock drops 16 cycles after req 2's last completion and pending req 4 is served.
- UART inserts 4 wait states with pslverr=1 on a write of "z": pready arrives only after the wait states, pslverr=1 is forwarded, and the lock is not taken.
- Assert rst_i during ACCESS: all outputs are 0 in the same cycle. After release, the first grant goes to index 0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART line arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } arb_state_e;

  localparam logic [7:0] AsciiLf = 8'h0A;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned NumReq = 8,
  localparam int unsigned IdxW = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic              valid_o,
  output logic [IdxW-1:0]   idx_o
);

  int unsigned     cand;
  logic [IdxW-1:0] cidx;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    cidx    = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = (32'(ptr_i) + i) % NumReq;
      cidx = IdxW'(cand);
      if (!valid_o && req_i[cidx]) begin
        valid_o = 1'b1;
        idx_o   = cidx;
      end
    end
  end

endmodule

// File: rtl/uart_line_arbiter.sv
// Round-robin APB arbiter in front of one mock UART, with a per-line lock so that
// printf output from different requesters never interleaves within a line.
module uart_line_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned          NumReq        = 8,
  parameter int unsigned          AddrWidth     = 32,
  parameter int unsigned          TimeoutCycles = 1024,
  parameter logic [AddrWidth-1:0] TxAddrOffset  = '0,
  localparam int unsigned         IdxW          = $clog2(NumReq)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumReq-1:0]                slv_psel_i,
  input  logic [NumReq-1:0]                slv_penable_i,
  input  logic [NumReq-1:0]                slv_pwrite_i,
  input  logic [NumReq-1:0][AddrWidth-1:0] slv_paddr_i,
  input  logic [NumReq-1:0][31:0]          slv_pwdata_i,
  output logic [NumReq-1:0]                slv_pready_o,
  output logic [NumReq-1:0][31:0]          slv_prdata_o,
  output logic [NumReq-1:0]                slv_pslverr_o,
  output logic                             mst_psel_o,
  output logic                             mst_penable_o,
  output logic                             mst_pwrite_o,
  output logic [AddrWidth-1:0]             mst_paddr_o,
  output logic [31:0]                      mst_pwdata_o,
  input  logic                             mst_pready_i,
  input  logic [31:0]                      mst_prdata_i,
  input  logic                             mst_pslverr_i,
  output logic                             lock_valid_o,
  output logic [IdxW-1:0]                  lock_owner_o
);

  localparam int unsigned      CntW   = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0]  CntMax = CntW'(TimeoutCycles - 1);

  arb_state_e           state_q, state_d;
  logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]      grant_q, grant_d;
  logic                 pwrite_q, pwrite_d;
  logic [AddrWidth-1:0] paddr_q, paddr_d;
  logic [31:0]          pwdata_q, pwdata_d;
  logic                 lock_valid_q, lock_valid_d;
  logic [IdxW-1:0]      lock_owner_q, lock_owner_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  logic [NumReq-1:0] owner_mask, eligible;
  logic              pick_valid;
  logic [IdxW-1:0]   pick_idx;
  logic              xfer_done, owner_grant;

  assign owner_mask = NumReq'(1) << lock_owner_q;
  assign eligible   = lock_valid_q ? (slv_psel_i & owner_mask) : slv_psel_i;

  uart_rr_pick #(
    .NumReq(NumReq)
  ) u_pick (
    .req_i  (eligible),
    .ptr_i  (rr_ptr_q),
    .valid_o(pick_valid),
    .idx_o  (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    cnt_d        = cnt_q;
    xfer_done    = 1'b0;
    owner_grant  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d     = SETUP;
          grant_d     = pick_idx;
          pwrite_d    = slv_pwrite_i[pick_idx];
          paddr_d     = slv_paddr_i[pick_idx];
          pwdata_d    = slv_pwdata_i[pick_idx];
          owner_grant = lock_valid_q;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (mst_pready_i) begin
          state_d   = IDLE;
          xfer_done = 1'b1;
          rr_ptr_d  = (grant_q == IdxW'(NumReq - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Idle timer only runs while the owner is silent; it saturates at CntMax.
    if (owner_grant || !lock_valid_q) begin
      cnt_d = '0;
    end else if (state_q == IDLE && !slv_psel_i[lock_owner_q] && cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (lock_valid_q && !owner_grant && cnt_q == CntMax) begin
      lock_valid_d = 1'b0;
    end

    if (xfer_done && pwrite_q && !mst_pslverr_i && paddr_q == TxAddrOffset) begin
      if (pwdata_q[7:0] != AsciiLf) begin
        lock_valid_d = 1'b1;
        lock_owner_d = grant_q;
        cnt_d        = '0;
      end else begin
        lock_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      cnt_q        <= cnt_d;
    end
  end

  assign mst_psel_o    = (state_q != IDLE);
  assign mst_penable_o = (state_q == ACCESS);
  assign mst_pwrite_o  = pwrite_q;
  assign mst_paddr_o   = paddr_q;
  assign mst_pwdata_o  = pwdata_q;
  assign lock_valid_o  = lock_valid_q;
  assign lock_owner_o  = lock_owner_q;

  // Response path is combinational so a zero-wait UART completes in one ACCESS cycle.
  always_comb begin
    slv_pready_o  = '0;
    slv_prdata_o  = '0;
    slv_pslverr_o = '0;
    if (state_q == ACCESS) begin
      slv_pready_o[grant_q]  = mst_pready_i & slv_penable_i[grant_q];
      slv_prdata_o[grant_q]  = mst_prdata_i;
      slv_pslverr_o[grant_q] = mst_pslverr_i;
    end
  end

endmodule

// File: tb/tb_uart_line_arbiter.sv
// Directed self-checking bench for uart_line_arbiter with a small mock UART.
module tb_uart_line_arbiter;

  localparam int unsigned NR = 8;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NR-1:0]          slv_psel, slv_penable, slv_pwrite;
  logic [NR-1:0][AW-1:0]  slv_paddr;
  logic [NR-1:0][31:0]    slv_pwdata;
  logic [NR-1:0]          slv_pready, slv_pslverr;
  logic [NR-1:0][31:0]    slv_prdata;
  logic                   mst_psel, mst_penable, mst_pwrite, mst_pready, mst_pslverr;
  logic [AW-1:0]          mst_paddr;
  logic [31:0]            mst_pwdata, mst_prdata;
  logic                   lock_valid;
  logic [2:0]             lock_owner;

  int unsigned            uart_waits;
  int unsigned            wcnt = 0;
  logic                   uart_err;

  int                     errors = 0;
  int                     checks = 0;
  logic [NR-1:0]          smp_pready, smp_err;
  logic [NR-1:0][31:0]    smp_rdata;
  int                     n, who;
  logic                   seen3;
  logic [7:0]             chars [3];
  logic                   lock_exp [3];

  uart_line_arbiter #(
    .NumReq       (NR),
    .AddrWidth    (AW),
    .TimeoutCycles(TO),
    .TxAddrOffset (32'h0)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .slv_psel_i   (slv_psel),
    .slv_penable_i(slv_penable),
    .slv_pwrite_i (slv_pwrite),
    .slv_paddr_i  (slv_paddr),
    .slv_pwdata_i (slv_pwdata),
    .slv_pready_o (slv_pready),
    .slv_prdata_o (slv_prdata),
    .slv_pslverr_o(slv_pslverr),
    .mst_psel_o   (mst_psel),
    .mst_penable_o(mst_penable),
    .mst_pwrite_o (mst_pwrite),
    .mst_paddr_o  (mst_paddr),
    .mst_pwdata_o (mst_pwdata),
    .mst_pready_i (mst_pready),
    .mst_prdata_i (mst_prdata),
    .mst_pslverr_i(mst_pslverr),
    .lock_valid_o (lock_valid),
    .lock_owner_o (lock_owner)
  );

  always #5 clk = ~clk;

  // Mock UART: uart_waits wait states per transfer, read data derived from address.
  always @(posedge clk) begin
    if (mst_psel && mst_penable && !mst_pready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end
  assign mst_pready  = mst_psel && mst_penable && (wcnt >= uart_waits);
  assign mst_pslverr = uart_err && mst_pready;
  assign mst_prdata  = 32'hDA7A_0000 ^ mst_paddr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample responses mid-cycle, then step to just after the next edge and
  // release any requester that was just served.
  task automatic adv();
    @(negedge clk);
    smp_pready = slv_pready;
    smp_err    = slv_pslverr;
    smp_rdata  = slv_prdata;
    @(posedge clk);
    #1;
    slv_psel    = slv_psel & ~smp_pready;
    slv_penable = slv_psel;
  endtask

  task automatic run_until(input logic [NR-1:0] mask, input int max_cyc,
                           output int cyc, output int idx);
    cyc = 0;
    idx = -1;
    while (idx < 0 && cyc < max_cyc) begin
      adv();
      cyc++;
      for (int i = 0; i < NR; i++) if (idx < 0 && mask[i] && smp_pready[i]) idx = i;
    end
  endtask

  task automatic req_on(input int i, input logic we, input logic [31:0] a,
                        input logic [31:0] d);
    slv_psel[i]   = 1'b1;
    slv_pwrite[i] = we;
    slv_paddr[i]  = a;
    slv_pwdata[i] = d;
  endtask

  initial begin
    rst         = 1'b1;
    slv_psel    = '0;
    slv_penable = '0;
    slv_pwrite  = '0;
    slv_paddr   = '0;
    slv_pwdata  = '0;
    uart_waits  = 0;
    uart_err    = 1'b0;
    smp_pready  = '0;
    smp_err     = '0;
    smp_rdata   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mst_psel", 64'(mst_psel), 64'(0));
    chk("rst_mst_penable", 64'(mst_penable), 64'(0));
    chk("rst_mst_paddr", 64'(mst_paddr), 64'(0));
    chk("rst_slv_pready", 64'(slv_pready), 64'(0));
    chk("rst_lock", 64'({lock_valid, lock_owner}), 64'(0));
    rst = 1'b0;

    // Two readers contend with no lock: strict alternation.
    req_on(0, 1'b0, 32'h10, 32'h0);
    req_on(5, 1'b0, 32'h54, 32'h0);
    for (int k = 0; k < 4; k++) begin
      run_until(8'h21, 10, n, who);
      chk("rr_who", 64'(who), 64'((k % 2 == 0) ? 0 : 5));
      chk("rr_lat", 64'(n), 64'(3));
      if (k == 0) begin
        chk("rr_pready_vec", 64'(smp_pready), 64'(8'h01));
        chk("rr_rdata0", 64'(smp_rdata[0]), 64'(32'hDA7A_0010));
        chk("rr_rdata5_idle", 64'(smp_rdata[5]), 64'(0));
      end
      if (k == 1) chk("rr_rdata5", 64'(smp_rdata[5]), 64'(32'hDA7A_0054));
      if (k < 2) req_on(who, 1'b0, (who == 0) ? 32'h10 : 32'h54, 32'h0);
    end
    chk("rr_no_lock", 64'(lock_valid), 64'(0));

    // Single writer: "A", "B", LF.
    chars    = '{8'h41, 8'h42, 8'h0A};
    lock_exp = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      req_on(0, 1'b1, 32'h0, {24'h0, chars[k]});
      run_until(8'h01, 10, n, who);
      chk("line_who", 64'(who), 64'(0));
      chk("line_lat", 64'(n), 64'(3));
      chk("line_wdata", 64'(mst_pwdata), 64'({24'h0, chars[k]}));
      chk("line_lock", 64'(lock_valid), 64'(lock_exp[k]));
    end

    // Lock held by req 2 blocks req 3 until LF.
    req_on(2, 1'b1, 32'h0, 32'h78);
    run_until(8'h04, 10, n, who);
    chk("hold_who", 64'(who), 64'(2));
    chk("hold_lock", 64'({lock_valid, lock_owner}), 64'({1'b1, 3'd2}));
    req_on(3, 1'b0, 32'h30, 32'h0);
    seen3 = 1'b0;
    repeat (6) begin
      adv();
      seen3 |= smp_pready[3];
    end
    chk("hold_blocked", 64'(seen3), 64'(0));
    chk("hold_mst_idle", 64'(mst_psel), 64'(0));
    req_on(2, 1'b1, 32'h0, 32'h0A);
    run_until(8'h0C, 10, n, who);
    chk("hold_lf_who", 64'(who), 64'(2));
    chk("hold_released", 64'(lock_valid), 64'(0));
    run_until(8'h08, 10, n, who);
    chk("hold_r3_who", 64'(who), 64'(3));
    chk("hold_r3_lat", 64'(n), 64'(3));
    chk("hold_r3_rdata", 64'(smp_rdata[3]), 64'(32'hDA7A_0030));

    // Lock dropped by timeout after 16 idle cycles.
    req_on(2, 1'b1, 32'h0, 32'h79);
    run_until(8'h04, 10, n, who);
    chk("tmo_take", 64'({lock_valid, lock_owner}), 64'({1'b1, 3'd2}));
    req_on(4, 1'b0, 32'h44, 32'h0);
    repeat (15) adv();
    chk("tmo_still_locked", 64'(lock_valid), 64'(1));
    chk("tmo_r4_waiting", 64'(slv_psel[4]), 64'(1));
    adv();
    chk("tmo_dropped", 64'(lock_valid), 64'(0));
    run_until(8'h10, 10, n, who);
    chk("tmo_r4_who", 64'(who), 64'(4));
    chk("tmo_r4_lat", 64'(n), 64'(3));
    chk("tmo_r4_rdata", 64'(smp_rdata[4]), 64'(32'hDA7A_0044));

    // Wait states plus error on a TX write: forwarded, no lock.
    uart_waits = 4;
    uart_err   = 1'b1;
    req_on(1, 1'b1, 32'h0, 32'h7A);
    run_until(8'h02, 20, n, who);
    chk("err_who", 64'(who), 64'(1));
    chk("err_lat", 64'(n), 64'(7));
    chk("err_pslverr", 64'(smp_err[1]), 64'(1));
    chk("err_no_lock", 64'(lock_valid), 64'(0));
    uart_err = 1'b0;

    // Reset in ACCESS aborts; afterwards index 0 wins first.
    req_on(3, 1'b0, 32'h3C, 32'h0);
    req_on(0, 1'b0, 32'h08, 32'h0);
    repeat (3) adv();
    chk("abort_in_access", 64'({mst_psel, mst_penable}), 64'(2'b11));
    chk("abort_paddr", 64'(mst_paddr), 64'(32'h3C));
    rst = 1'b1;
    #1;
    chk("abort_mst", 64'({mst_psel, mst_penable, mst_pwrite}), 64'(0));
    chk("abort_mst_addr", 64'(mst_paddr), 64'(0));
    chk("abort_slv", 64'({slv_pready, slv_pslverr}), 64'(0));
    chk("abort_prdata", 64'(slv_prdata === '0), 64'(1));
    chk("abort_lock", 64'({lock_valid, lock_owner}), 64'(0));
    @(posedge clk);
    #1;
    rst        = 1'b0;
    uart_waits = 0;
    run_until(8'h09, 10, n, who);
    chk("post_rst_who", 64'(who), 64'(0));
    chk("post_rst_lat", 64'(n), 64'(3));
    run_until(8'h08, 10, n, who);
    chk("post_rst_r3", 64'(who), 64'(3));
    chk("post_rst_r3_rdata", 64'(smp_rdata[3]), 64'(32'hDA7A_003C));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
